// File: rtl/wb_pkg.sv
// Shared write-back constants for the RV32I core.
// Result-source selects and load funct3 encodings, reused by decode.
package wb_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_aligner.sv
// Extracts and extends load data from an aligned little-endian word.
// Unsupported funct3 codes pass the raw word through.
module load_aligner
    import wb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] value
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed byte/halfword, then extend by load type
    always_comb begin
        byte_v = word[{offset, 3'b000} +: 8];
        half_v = offset[1] ? word[31:16] : word[15:0];
        value  = word;
        case (funct3)
            F3_LB:   value = {{24{byte_v[7]}}, byte_v};
            F3_LBU:  value = {24'h0, byte_v};
            F3_LH:   value = {{16{half_v[15]}}, half_v};
            F3_LHU:  value = {16'h0, half_v};
            F3_LW:   value = word;
            default: value = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, write-back mux and retired-instruction counter.
// All outputs come from registered state only.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_DEPTH = 32,
    localparam int AW       = $clog2(REG_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_reg_we,
    input  logic [AW-1:0]     mem_rd,
    input  logic [1:0]        mem_wb_sel,
    input  logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_pc_plus4,
    input  logic [DATA_W-1:0] mem_load_word,
    output logic              we,
    output logic [DATA_W-1:0] Rin,
    output logic [AW-1:0]     D_addr,
    output logic              wb_valid,
    output logic              fwd_valid,
    output logic [AW-1:0]     fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [63:0]       instret
);

    logic              valid_q;
    logic              reg_we_q;
    logic [AW-1:0]     rd_q;
    logic [1:0]        wb_sel_q;
    logic [2:0]        funct3_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] pc4_q;
    logic [DATA_W-1:0] word_q;
    logic [63:0]       instret_q;
    logic [DATA_W-1:0] load_v;
    logic [DATA_W-1:0] rin_v;

    // WB register: reset > flush > stall > capture; count leaving instrs
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            reg_we_q  <= 1'b0;
            rd_q      <= '0;
            wb_sel_q  <= '0;
            funct3_q  <= '0;
            alu_q     <= '0;
            pc4_q     <= '0;
            word_q    <= '0;
            instret_q <= '0;
        end else begin
            if (valid_q && !stall)
                instret_q <= instret_q + 64'd1;
            if (flush) begin
                valid_q  <= 1'b0;
                reg_we_q <= 1'b0;
            end else if (!stall) begin
                valid_q  <= mem_valid;
                reg_we_q <= mem_reg_we;
                rd_q     <= mem_rd;
                wb_sel_q <= mem_wb_sel;
                funct3_q <= mem_funct3;
                alu_q    <= mem_alu_result;
                pc4_q    <= mem_pc_plus4;
                word_q   <= mem_load_word;
            end
        end
    end

    load_aligner u_align (
        .funct3 (funct3_q),
        .offset (alu_q[1:0]),
        .word   (word_q),
        .value  (load_v)
    );

    // Write-back source select; reserved code falls back to ALU
    always_comb begin
        rin_v = alu_q;
        case (wb_sel_q)
            WB_SEL_LOAD: rin_v = load_v;
            WB_SEL_PC4:  rin_v = pc4_q;
            default:     rin_v = alu_q;
        endcase
    end

    assign we        = valid_q & reg_we_q & (rd_q != '0);
    assign Rin       = rin_v;
    assign D_addr    = rd_q;
    assign wb_valid  = valid_q;
    assign fwd_valid = we;
    assign fwd_addr  = rd_q;
    assign fwd_data  = rin_v;
    assign instret   = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage.
// Directed steps plus random traffic against a behavioural model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        mem_valid, mem_reg_we;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result, mem_pc_plus4, mem_load_word;
    logic        we, wb_valid, fwd_valid;
    logic [31:0] Rin, fwd_data;
    logic [4:0]  D_addr, fwd_addr;
    logic [63:0] instret;

    int tests = 0;
    int fails = 0;

    // model state: what the WB stage architecturally holds
    bit              m_valid, m_we, m_known;
    int unsigned     m_rd, m_sel, m_f3;
    bit [31:0]       m_alu, m_pc4, m_word;
    longint unsigned m_instret;

    writeback_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_we(mem_reg_we),
        .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel),
        .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result),
        .mem_pc_plus4(mem_pc_plus4), .mem_load_word(mem_load_word),
        .we(we), .Rin(Rin), .D_addr(D_addr), .wb_valid(wb_valid),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic bit [31:0] ref_load(int unsigned f3,
                                           int unsigned off,
                                           bit [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * off)) % 256;
        h = (w >> (16 * (off / 2))) % 65536;
        case (f3)
            0: return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            4: return 32'(b);
            1: return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            5: return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic bit [31:0] ref_rin();
        if (m_sel == 1) return ref_load(m_f3, m_alu % 4, m_word);
        if (m_sel == 2) return m_pc4;
        return m_alu;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit w, input int unsigned rd,
                         input int unsigned sel, input int unsigned f3,
                         input bit [31:0] alu, input bit [31:0] pc4,
                         input bit [31:0] word);
        mem_valid      = v;
        mem_reg_we     = w;
        mem_rd         = 5'(rd);
        mem_wb_sel     = 2'(sel);
        mem_funct3     = 3'(f3);
        mem_alu_result = alu;
        mem_pc_plus4   = pc4;
        mem_load_word  = word;
    endtask

    task automatic cycle();
        bit exp_we;
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_we = 0; m_rd = 0; m_sel = 0; m_f3 = 0;
            m_alu = 0; m_pc4 = 0; m_word = 0; m_instret = 0;
            m_known = 1;
        end else begin
            if (m_valid && !stall) m_instret++;
            if (flush) begin
                m_valid = 0; m_we = 0; m_known = 0;
            end else if (!stall) begin
                m_valid = mem_valid; m_we = mem_reg_we;
                m_rd = mem_rd; m_sel = mem_wb_sel; m_f3 = mem_funct3;
                m_alu = mem_alu_result; m_pc4 = mem_pc_plus4;
                m_word = mem_load_word; m_known = 1;
            end
        end
        #1;
        exp_we = m_valid && m_we && m_rd != 0;
        chk("wb_valid", 64'(wb_valid), 64'(m_valid));
        chk("we", 64'(we), 64'(exp_we));
        chk("fwd_valid", 64'(fwd_valid), 64'(exp_we));
        chk("instret", instret, m_instret);
        if (m_known) begin
            chk("D_addr", 64'(D_addr), 64'(m_rd));
            chk("fwd_addr", 64'(fwd_addr), 64'(m_rd));
            chk("Rin", 64'(Rin), 64'(ref_rin()));
            chk("fwd_data", 64'(fwd_data), 64'(ref_rin()));
        end
    endtask

    initial begin : main
        bit [31:0]   lw_val;
        int unsigned ld_f3[9];
        int unsigned ld_off[9];
        bit [31:0]   ld_exp[9];
        logic [31:0] hold_rin;
        logic [63:0] hold_ir;

        lw_val = 32'h8081_7F80;
        ld_f3  = '{0, 0, 0, 0, 4, 1, 5, 3, 2};
        ld_off = '{0, 1, 2, 3, 3, 2, 0, 1, 2};
        ld_exp = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_FF81,
                   32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8081,
                   32'h0000_7F80, 32'h8081_7F80, 32'h8081_7F80};

        reset = 1; stall = 0; flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        m_known = 0; m_instret = 0;
        cycle(); cycle();
        reset = 0;
        cycle();
        chk("rst_instret", instret, 64'd0);
        chk("rst_Rin", 64'(Rin), 64'd0);
        chk("rst_we", 64'(we), 64'd0);

        drive(1, 1, 5, 0, 0, 32'h0000_1234, 0, 0);
        cycle();
        chk("alu_we", 64'(we), 64'd1);
        chk("alu_addr", 64'(D_addr), 64'd5);
        chk("alu_rin", 64'(Rin), 64'h1234);
        drive(1, 1, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
        cycle();
        chk("x0_we", 64'(we), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("x0_instret", instret, 64'd2);

        for (int i = 0; i < 9; i++) begin
            drive(1, 1, 7, 1, ld_f3[i], 32'h1000 + ld_off[i], 0, lw_val);
            cycle();
            chk($sformatf("load%0d", i), 64'(Rin), 64'(ld_exp[i]));
        end

        drive(1, 1, 1, 2, 0, 32'hDEAD_BEEF, 32'h0000_0104, 0);
        cycle();
        chk("jal_rin", 64'(Rin), 64'h104);
        chk("jal_fwd", 64'(fwd_data), 64'h104);

        hold_rin = Rin;
        hold_ir  = instret;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 9, 0, 0, $urandom, $urandom, $urandom);
            cycle();
            chk("stall_rin", 64'(Rin), 64'(hold_rin));
            chk("stall_ir", instret, hold_ir);
        end
        flush = 1;
        cycle();
        chk("flush_valid", 64'(wb_valid), 64'd0);
        chk("flush_we", 64'(we), 64'd0);
        stall = 0; flush = 0;

        drive(1, 1, 3, 0, 0, 32'h55, 0, 0);
        stall = 1;
        cycle();
        stall = 0;
        cycle();
        stall = 1;
        cycle();
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        stall = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("wrap", instret, 64'd0);

        drive(1, 1, 9, 0, 0, 32'h77, 0, 0);
        cycle();
        chk("pre_rst_we", 64'(we), 64'd1);
        reset = 1;
        stall = 1;
        drive(1, 1, 10, 0, 0, 32'h88, 0, 0);
        cycle();
        chk("mid_rst_we", 64'(we), 64'd0);
        chk("mid_rst_ir", instret, 64'd0);
        reset = 0;
        stall = 0;

        for (int i = 0; i < 300; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 31), $urandom_range(0, 3),
                  $urandom_range(0, 7), $urandom, $urandom, $urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
